// File: rtl/conv_out_requant.sv
// Requantises 32-bit conv accumulators to int8 (leaky ReLU, rounding shift, saturation) with row/frame tags.
// Latency: word sampled at edge N is written to the output FIFO at edge N+3, visible at the head the cycle after.
// Backpressure: none on the input; out_ready stalls the FIFO head, and words arriving at a full FIFO are dropped.

// Generic synchronous FIFO with first-word fall-through head and a registered almost-full flag.
// Latency: a pushed word reaches the head one cycle after its push edge (no bypass).
// Backpressure: a push while full is dropped unless a pop happens in the same cycle; drop pulses for it.
module fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             almost_full,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             push;

    assign head_vld = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = head_vld && pop_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = push_vld && (!full || pop);
    assign drop     = push_vld && full && !pop;
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            almost_full <= (count >= (AW+1)'(AF_LVL));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_dat;
    end
endmodule

// Accumulator-to-int8 requantiser: S1 leaky ReLU, S2 rounding right shift, S3 saturate, then output FIFO.
// Latency: 3 register stages before the FIFO write; first-word fall-through at the FIFO head.
// Backpressure: input is never stalled; almost_full hints upstream, overflow is sticky once a word is lost.
module conv_out_requant #(
    parameter int OUT_W      = 8,
    parameter int OUT_H      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [31:0] in_acc,
    input  logic [4:0]         shift,
    input  logic               leaky_en,
    output logic signed [7:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_eol,
    output logic               out_eof,
    output logic               almost_full,
    output logic               overflow
);
    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          in_eol;
    logic          in_eof;

    assign in_eol = (col == CW'(OUT_W - 1));
    assign in_eof = in_eol && (row == RW'(OUT_H - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (in_eol) begin
                col <= '0;
                row <= in_eof ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    logic               s1_vld;
    logic signed [31:0] s1_v;
    logic [4:0]         s1_shift;
    logic               s1_eol;
    logic               s1_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_v     <= '0;
            s1_shift <= '0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
        end else begin
            s1_vld   <= in_valid;
            s1_v     <= (leaky_en && in_acc < 0) ? (in_acc >>> 3) : in_acc;
            s1_shift <= shift;
            s1_eol   <= in_eol;
            s1_eof   <= in_eof;
        end
    end

    // One extra bit keeps v + half-LSB from wrapping for any 32-bit v and shift.
    logic signed [32:0] s2_ext;
    logic signed [32:0] s2_rnd;
    logic signed [32:0] s2_sum;

    assign s2_ext = {s1_v[31], s1_v};
    assign s2_rnd = (s1_shift != 5'd0) ? (33'sd1 <<< (s1_shift - 5'd1)) : 33'sd0;
    assign s2_sum = s2_ext + s2_rnd;

    logic               s2_vld;
    logic signed [32:0] s2_r;
    logic               s2_eol;
    logic               s2_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_r   <= '0;
            s2_eol <= 1'b0;
            s2_eof <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            s2_r   <= s2_sum >>> s1_shift;
            s2_eol <= s1_eol;
            s2_eof <= s1_eof;
        end
    end

    logic [7:0] s3_sat;

    always_comb begin
        s3_sat = s2_r[7:0];
        if (s2_r > 33'sd127)
            s3_sat = 8'h7f;
        else if (s2_r < -33'sd128)
            s3_sat = 8'h80;
    end

    logic       s3_vld;
    logic [9:0] s3_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_vld <= 1'b0;
            s3_dat <= '0;
        end else begin
            s3_vld <= s2_vld;
            s3_dat <= {s2_eof, s2_eol, s3_sat};
        end
    end

    logic [9:0] head_dat;
    logic       fifo_drop;

    fifo #(
        .WIDTH  (10),
        .DEPTH  (FIFO_DEPTH),
        .AF_LVL (FIFO_DEPTH - 4)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_vld    (s3_vld),
        .push_dat    (s3_dat),
        .pop_rdy     (out_ready),
        .head_vld    (out_valid),
        .head_dat    (head_dat),
        .almost_full (almost_full),
        .drop        (fifo_drop)
    );

    assign out_data = head_dat[7:0];
    assign out_eol  = head_dat[8];
    assign out_eof  = head_dat[9];

    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (fifo_drop)
            overflow <= 1'b1;
    end
endmodule

// File: tb/tb_conv_out_requant.sv
// Directed bench for conv_out_requant: arithmetic vectors, frame tagging, FIFO overflow and mid-frame reset.
module tb_conv_out_requant;
    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [31:0] in_acc;
    logic [4:0]         shift;
    logic               leaky_en;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_eol;
    logic               out_eof;
    logic               almost_full;
    logic               overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_out_requant #(
        .OUT_W      (8),
        .OUT_H      (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_acc      (in_acc),
        .shift       (shift),
        .leaky_en    (leaky_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // One isolated word; the FIFO head must appear exactly after the third edge following the sample edge.
    task automatic send_one(input string name, input logic signed [31:0] acc, input logic [4:0] sh,
                            input logic lk, input logic signed [31:0] exp);
        in_acc   = acc;
        shift    = sh;
        leaky_en = lk;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk({name, "_early"}, out_valid, 0);
        step();
        chk({name, "_vld"}, out_valid, 1);
        chk({name, "_dat"}, out_data, exp);
        step();
    endtask

    // Streams n words (acc = index mod 100) from a frame start and checks data and tags in order.
    task automatic stream(input string name, input int n);
        int rx = 0;
        out_ready = 1'b1;
        shift     = 5'd0;
        leaky_en  = 1'b0;
        for (int c = 0; c < n + 8; c++) begin
            in_valid = (c < n);
            in_acc   = c % 100;
            step();
            if (out_valid) begin
                chk({name, "_dat"}, out_data, rx % 100);
                chk({name, "_eol"}, out_eol, (rx % 8) == 7);
                chk({name, "_eof"}, out_eof, (rx % 64) == 63);
                rx++;
            end
        end
        in_valid = 1'b0;
        chk({name, "_cnt"}, rx, n);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_acc    = '0;
        shift     = '0;
        leaky_en  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        step();
        chk("rst_vld", out_valid, 0);
        chk("rst_dat", out_data, 0);
        chk("rst_eol", out_eol, 0);
        chk("rst_eof", out_eof, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;

        out_ready = 1'b1;
        send_one("pos_shift4", 32'sd1000, 5'd4, 1'b0, 63);
        send_one("leaky_neg", -32'sd800, 5'd2, 1'b1, -25);
        send_one("neg_sat", -32'sd800, 5'd2, 1'b0, -128);
        send_one("big_pos", 32'sd100000, 5'd0, 1'b0, 127);
        send_one("big_neg", -32'sd100000, 5'd0, 1'b0, -128);
        send_one("rnd_pos", 32'sd5, 5'd1, 1'b0, 3);
        send_one("rnd_neg", -32'sd5, 5'd1, 1'b0, -2);
        send_one("leaky_pos", 32'sd40, 5'd3, 1'b1, 5);
        send_one("leaky_floor", -32'sd9, 5'd0, 1'b1, -2);
        send_one("max_shift31", 32'sh7fffffff, 5'd31, 1'b0, 1);

        do_reset();
        stream("frames", 128);

        do_reset();
        out_ready = 1'b0;
        shift     = 5'd0;
        leaky_en  = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            in_acc   = j;
            in_valid = 1'b1;
            step();
            if (j == 15)
                chk("af_pre", almost_full, 0);
            if (j == 16)
                chk("af_set", almost_full, 1);
        end
        in_valid = 1'b0;
        step();
        step();
        chk("ovf_pre", overflow, 0);
        step();
        chk("ovf_set", overflow, 1);
        chk("full_vld", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_vld", out_valid, 1);
            chk("drain_dat", out_data, i);
            chk("drain_eol", out_eol, (i % 8) == 0);
            step();
        end
        chk("drain_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);

        for (int k = 0; k < 20; k++) begin
            in_acc   = k;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_af", almost_full, 0);
        stream("post_rst", 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
